refclk_obufds_seq: RTL and testbench

Parametrised multi-channel successor to the single-channel GT reference-clock differential output buffer. Drives NUM_CH differential refclk output pairs and adds what the single-channel buffer lacks:
- a clocked enable sequencer that brings up one channel at a time, with a settle delay and optional inter-channel stagger, to limit simultaneous switching;
- immediate per-channel disable;
- per-channel drive-current (ICNTL) registers that are writable only while the channel is off.

It sits between the GT common/refclk logic and the refclk output pins.

---
 rtl/refclk_obufds_seq.sv | 145 ++++++++++++++
 tb/tb_refclk_obufds_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/refclk_obufds_seq.sv
// Multi-channel GT refclk differential output buffer with a one-at-a-time enable sequencer.
// Build option: define REFCLK_SEQ_STAGGER_EN to insert the inter-channel GAP state.
module refclk_obufds_seq #(
    parameter int unsigned NUM_CH            = 4,
    parameter int unsigned SETTLE_CYCLES     = 16,
    parameter int unsigned STAGGER_CYCLES    = 4,
    parameter logic [NUM_CH-1:0]   REFCLK_EN_TX_PATH = {NUM_CH{1'b1}},
    parameter logic [5*NUM_CH-1:0] REFCLK_ICNTL_TX   = {NUM_CH{5'b00000}},
    localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  GTS,
    input  logic [NUM_CH-1:0]     CEB,
    input  logic [NUM_CH-1:0]     I,
    output logic [NUM_CH-1:0]     O,
    output logic [NUM_CH-1:0]     OB,
    output logic [NUM_CH-1:0]     RDY,
    output logic                  BUSY,
    input  logic                  ICNTL_WE,
    input  logic [CW-1:0]         ICNTL_CH,
    input  logic [4:0]            ICNTL_D,
    output logic [5*NUM_CH-1:0]   ICNTL_Q,
    output logic                  ERR
);

    localparam int unsigned CNT_MAX = (SETTLE_CYCLES > STAGGER_CYCLES) ? SETTLE_CYCLES : STAGGER_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

`ifdef REFCLK_SEQ_STAGGER_EN
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(STAGGER_CYCLES - 1);
    typedef enum logic [1:0] {IDLE, SETTLE, GAP} state_t;
`else
    typedef enum logic [0:0] {IDLE, SETTLE} state_t;
`endif

    state_t                     state, state_d;
    logic [CNT_W-1:0]           cnt, cnt_d;
    logic [CW-1:0]              cur, cur_d;
    logic [NUM_CH-1:0]          en, en_set;
    logic [NUM_CH-1:0][4:0]     icntl_q;
    logic                       err_q;

    logic [NUM_CH-1:0]          req, pending, drive;
    logic [CW-1:0]              pick;
    logic                       found;
    logic                       busy;
    logic                       wr_ok;

    assign req     = ~CEB & REFCLK_EN_TX_PATH;
    assign pending = req & ~en;
    assign busy    = (state != IDLE);

    // Reverse scan so the last hit is the lowest pending channel.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = NUM_CH; k > 0; k--) begin
            if (pending[k-1]) begin
                found = 1'b1;
                pick  = CW'(k - 1);
            end
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        cur_d   = cur;
        en_set  = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    cur_d   = pick;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                cnt_d = cnt + 1'b1;
                if (!req[cur]) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt == SETTLE_LAST) begin
                    en_set[cur] = 1'b1;
                    cnt_d       = '0;
`ifdef REFCLK_SEQ_STAGGER_EN
                    state_d     = GAP;
`else
                    state_d     = IDLE;
`endif
                end
            end
`ifdef REFCLK_SEQ_STAGGER_EN
            GAP: begin
                cnt_d = cnt + 1'b1;
                if (cnt == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // The channel being settled is locked against ICNTL writes until it completes or aborts.
    assign wr_ok = (32'(ICNTL_CH) < NUM_CH) && !en[ICNTL_CH] && !(busy && (ICNTL_CH == cur));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            cnt     <= '0;
            cur     <= '0;
            en      <= '0;
            icntl_q <= REFCLK_ICNTL_TX;
            err_q   <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            cur   <= cur_d;
            en    <= (en & req) | en_set;
            err_q <= ICNTL_WE & ~wr_ok;
            if (ICNTL_WE && wr_ok) begin
                icntl_q[ICNTL_CH] <= ICNTL_D;
            end
        end
    end

    assign drive   = en & ~{NUM_CH{GTS}};
    assign RDY     = en;
    assign BUSY    = busy;
    assign ERR     = err_q;
    assign ICNTL_Q = icntl_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_obuf
        assign O[g]  = drive[g] ? I[g]  : 1'bz;
        assign OB[g] = drive[g] ? ~I[g] : 1'bz;
    end

endmodule

// File: tb/tb_refclk_obufds_seq.sv
// Scoreboard bench for refclk_obufds_seq: a cycle-level reference model pushes expected state,
// a negedge monitor pops it and compares against the DUT. Honours REFCLK_SEQ_STAGGER_EN.
module tb_refclk_obufds_seq;

    localparam int unsigned NCH    = 5;
    localparam int unsigned SETTLE = 16;
    localparam int unsigned STAG   = 4;
    localparam int unsigned CW     = 3;
    localparam logic [NCH-1:0]   MASK      = 5'b01111;
    localparam logic [5*NCH-1:0] ICNTL_RST = 25'h0ABCDEF;
`ifdef REFCLK_SEQ_STAGGER_EN
    localparam int unsigned GAP_LEN = STAG;
`else
    localparam int unsigned GAP_LEN = 0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           gts = 1'b0;
    logic [NCH-1:0] ceb = '1;
    logic [NCH-1:0] i_in = '0;
    logic           we = 1'b0;
    logic [CW-1:0]  wch = '0;
    logic [4:0]     wd = '0;

    wire  [NCH-1:0]   o, ob;
    logic [NCH-1:0]   rdy;
    logic             busy, err;
    logic [5*NCH-1:0] icntl_q;

    always #5 clk = ~clk;

    refclk_obufds_seq #(
        .NUM_CH           (NCH),
        .SETTLE_CYCLES    (SETTLE),
        .STAGGER_CYCLES   (STAG),
        .REFCLK_EN_TX_PATH(MASK),
        .REFCLK_ICNTL_TX  (ICNTL_RST)
    ) dut (
        .CLK     (clk),
        .RST     (rst),
        .GTS     (gts),
        .CEB     (ceb),
        .I       (i_in),
        .O       (o),
        .OB      (ob),
        .RDY     (rdy),
        .BUSY    (busy),
        .ICNTL_WE(we),
        .ICNTL_CH(wch),
        .ICNTL_D (wd),
        .ICNTL_Q (icntl_q),
        .ERR     (err)
    );

    typedef struct packed {
        logic [NCH-1:0]   en;
        logic             busy;
        logic             err;
        logic [5*NCH-1:0] icntl;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: a timeline of absolute edge numbers rather than a state machine.
    bit [NCH-1:0] m_en;
    bit           m_active;
    int           m_cur;
    longint       m_edge, m_enable_at, m_idle_at;
    bit           m_err;
    bit [4:0]     m_icntl [NCH];

    function automatic void m_reset();
        logic [5*NCH-1:0] init = ICNTL_RST;
        m_en = '0; m_active = 0; m_cur = 0; m_err = 0;
        m_edge = 0; m_enable_at = 0; m_idle_at = 0;
        for (int c = 0; c < int'(NCH); c++) m_icntl[c] = init[5*c +: 5];
    endfunction

    function automatic void m_step();
        bit [NCH-1:0] req, nen;
        int k = -1;
        m_edge++;
        req = ~ceb & MASK;
        m_err = 0;
        if (we) begin
            if (int'(wch) < int'(NCH) && !m_en[wch] && !(m_active && int'(wch) == m_cur))
                m_icntl[wch] = wd;
            else
                m_err = 1;
        end
        nen = m_en & req;
        if (m_active) begin
            if (m_edge <= m_enable_at) begin
                if (!req[m_cur]) m_active = 0;
                else if (m_edge == m_enable_at) begin
                    nen[m_cur] = 1;
                    if (m_idle_at == m_enable_at) m_active = 0;
                end
            end else if (m_edge == m_idle_at) begin
                m_active = 0;
            end
        end else begin
            for (int c = int'(NCH) - 1; c >= 0; c--) if (req[c] && !m_en[c]) k = c;
            if (k >= 0) begin
                m_active    = 1;
                m_cur       = k;
                m_enable_at = m_edge + SETTLE;
                m_idle_at   = m_enable_at + GAP_LEN;
            end
        end
        m_en = nen;
    endfunction

    function automatic exp_t m_snapshot();
        exp_t s;
        s.en = m_en; s.busy = m_active; s.err = m_err;
        for (int c = 0; c < int'(NCH); c++) s.icntl[5*c +: 5] = m_icntl[c];
        return s;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m_reset();
        else     m_step();
        exp_q.push_back(m_snapshot());
    end

    // An async reset between edges leaves a stale entry behind; only the newest one applies.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            while (exp_q.size() > 1) void'(exp_q.pop_front());
            e = exp_q.pop_front();
            vectors++;
            if (rdy !== e.en) begin
                miscompares++;
                $display("FAIL rdy t=%0t got %b expected %b", $time, rdy, e.en);
            end
            if (busy !== e.busy) begin
                miscompares++;
                $display("FAIL busy t=%0t got %b expected %b", $time, busy, e.busy);
            end
            if (err !== e.err) begin
                miscompares++;
                $display("FAIL err t=%0t got %b expected %b", $time, err, e.err);
            end
            if (icntl_q !== e.icntl) begin
                miscompares++;
                $display("FAIL icntl t=%0t got %h expected %h", $time, icntl_q, e.icntl);
            end
            for (int c = 0; c < int'(NCH); c++) begin
                if (e.en[c] && !gts) begin
                    if (o[c] !== i_in[c] || ob[c] !== ~i_in[c]) begin
                        miscompares++;
                        $display("FAIL drive ch%0d t=%0t got o=%b ob=%b expected o=%b ob=%b",
                                 c, $time, o[c], ob[c], i_in[c], ~i_in[c]);
                    end
                end else if (o[c] === ~ob[c]) begin
                    miscompares++;
                    $display("FAIL hiz ch%0d t=%0t got o=%b ob=%b expected high-Z", c, $time, o[c], ob[c]);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input int ch, input logic [4:0] d);
        we = 1'b1; wch = CW'(ch); wd = d;
        tick(1);
        we = 1'b0;
    endtask

    initial begin
        tick(3);
        rst = 1'b0;
        i_in = 5'b10110;

        ceb[0] = 1'b0; tick(25);
        ceb = '1; tick(8);
        ceb[3:0] = '0; tick(4*21 + 10);

        ceb = '1; tick(8);
        ceb[1] = 1'b0; tick(9); ceb[1] = 1'b1; tick(5);

        wr(2, 5'h15); tick(2);
        ceb[2] = 1'b0; tick(20);
        wr(2, 5'h0A); tick(2);
        wr(5, 5'h1F); tick(2);
        ceb[3] = 1'b0; tick(4);
        wr(3, 5'h07); tick(20);

        i_in = 5'b01001;
        gts = 1'b1; tick(3); gts = 1'b0; tick(2);

        ceb = '1; tick(10);
        ceb[1] = 1'b0; tick(6);
        rst = 1'b1; tick(2); rst = 1'b0; tick(25);

        ceb = '1; tick(10);
        ceb[4] = 1'b0; tick(30);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 29) == 0) begin
                int idx = $urandom_range(0, NCH - 1);
                ceb[idx] = ~ceb[idx];
            end
            we   = ($urandom_range(0, 7) == 0);
            wch  = CW'($urandom_range(0, 7));
            wd   = 5'($urandom);
            gts  = ($urandom_range(0, 15) == 0);
            i_in = NCH'($urandom);
            rst  = ($urandom_range(0, 499) == 0);
            tick(1);
        end
        rst = 1'b0; we = 1'b0; gts = 1'b0;
        tick(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
